// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pipe
//  Purpose  : Pipelined barrel shifter with a valid/ready handshake.
//             SHAMT_W register stages; stage k shifts by 2**k when bit k of
//             the operand's shift amount is set. Modes: SLL, SRL, SRA and an
//             optional ROR. Results leave in acceptance order with their tag.
//  Config   : `define SHIFT_PIPE_ROTATE_EN to make op 2'b11 a rotate right.
//             When undefined, op 2'b11 behaves exactly like SRL and no wrap
//             logic is built.
//  Ports    : clock     - rising-edge clock
//             reset     - synchronous, active-high reset
//             in_valid  - operand presented
//             in_ready  - pipeline accepts this cycle
//             in_data   - operand (WIDTH = 2**SHAMT_W bits)
//             in_shamt  - shift amount (SHAMT_W bits)
//             in_op     - 00 SLL, 01 SRL, 10 SRA, 11 ROR/SRL
//             in_tag    - opaque tag carried with the operand
//             out_valid - result present
//             out_ready - consumer accepts result
//             out_data  - shifted result
//             out_tag   - tag belonging to out_data
//  Revision : 1.0 - initial release
// ============================================================================
module shift_pipe #(
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [(1<<SHAMT_W)-1:0]   in_data,
    input  logic [SHAMT_W-1:0]        in_shamt,
    input  logic [1:0]                in_op,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [(1<<SHAMT_W)-1:0]   out_data,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int               WIDTH  = 1 << SHAMT_W;
    localparam int               c_last = SHAMT_W - 1;
    localparam logic [WIDTH-1:0] c_ones = '1;

    localparam logic [1:0] c_op_sll = 2'b00;
    localparam logic [1:0] c_op_sra = 2'b10;
`ifdef SHIFT_PIPE_ROTATE_EN
    localparam logic [1:0] c_op_ror = 2'b11;
`endif

    // Whole pipe freezes when the output holds an unconsumed result; bubbles
    // are kept in place rather than squeezed out.
    logic w_stall;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int c_amt = 1 << k;

        // Stage inputs
        logic               w_v;
        logic [WIDTH-1:0]   w_d;
        logic [SHAMT_W-1:0] w_s;
        logic [1:0]         w_o;
        logic               w_sign;
        logic [TAG_W-1:0]   w_t;
        logic [WIDTH-1:0]   w_shifted;

        // Stage registers
        logic               r_valid;
        logic [WIDTH-1:0]   r_data;
        logic [SHAMT_W-1:0] r_shamt;
        logic [1:0]         r_op;
        logic               r_sign;
        logic [TAG_W-1:0]   r_tag;

        if (k == 0) begin : g_head
            // The sign is captured from the untouched operand so later stages
            // still fill with the original MSB after it has been shifted away.
            assign w_v    = in_valid;
            assign w_d    = in_data;
            assign w_s    = in_shamt;
            assign w_o    = in_op;
            assign w_sign = in_data[WIDTH-1];
            assign w_t    = in_tag;
        end else begin : g_body
            assign w_v    = g_stage[k-1].r_valid;
            assign w_d    = g_stage[k-1].r_data;
            assign w_s    = g_stage[k-1].r_shamt;
            assign w_o    = g_stage[k-1].r_op;
            assign w_sign = g_stage[k-1].r_sign;
            assign w_t    = g_stage[k-1].r_tag;
        end

        // The shift amount is consumed LSB first: each stage reads bit 0 and
        // hands the remaining bits on, shifted down by one.
        always_comb begin
            w_shifted = w_d;
            if (w_s[0]) begin
                case (w_o)
                    c_op_sll: w_shifted = w_d << c_amt;
                    c_op_sra: w_shifted = (w_d >> c_amt) |
                                          (w_sign ? ~(c_ones >> c_amt) : '0);
`ifdef SHIFT_PIPE_ROTATE_EN
                    c_op_ror: w_shifted = (w_d >> c_amt) | (w_d << (WIDTH - c_amt));
`endif
                    default:  w_shifted = w_d >> c_amt;
                endcase
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_shamt <= '0;
                r_op    <= '0;
                r_sign  <= 1'b0;
                r_tag   <= '0;
            end else if (!w_stall) begin
                r_valid <= w_v;
                r_data  <= w_shifted;
                r_shamt <= w_s >> 1;
                r_op    <= w_o;
                r_sign  <= w_sign;
                r_tag   <= w_t;
            end
        end
    end

    assign out_valid = g_stage[c_last].r_valid;
    assign out_data  = g_stage[c_last].r_data;
    assign out_tag   = g_stage[c_last].r_tag;

    assign w_stall  = out_valid && !out_ready;
    assign in_ready = reset || !w_stall;

    // Control fields of the final stage have no consumer.
    logic w_unused;
    assign w_unused = ^{g_stage[c_last].r_shamt, g_stage[c_last].r_op,
                        g_stage[c_last].r_sign};

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_pipe
//  Purpose  : Self-checking bench for shift_pipe (SHAMT_W=5, TAG_W=4).
//             A monitor pushes the expected result of every accepted operand
//             into a queue and pops/compares on every consumed result.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_pipe;

    localparam int SHAMT_W = 5;
    localparam int TAG_W   = 4;
    localparam int LAT     = SHAMT_W;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic [4:0]   in_shamt = '0;
    logic [1:0]   in_op = '0;
    logic [3:0]   in_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_data;
    logic [3:0]   out_tag;

    shift_pipe #(.SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int          cyc;
        bit          chk;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          run = 0;
    int          maxrun = 0;
    int          stall_cnt = 0;
    bit          lat_chk = 1'b0;
    bit          use_exp = 1'b0;
    bit          prst = 1'b0;
    bit          done = 1'b0;
    logic [31:0] exp_val = '0;
    bit          stall_prev = 1'b0;
    logic [31:0] held_d = '0;
    logic [3:0]  held_t = '0;

    // Reference: plain shift operators on the whole operand.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                          input int sh);
        case (op)
            2'd0:    return d << sh;
            2'd2:    return $signed(d) >>> sh;
`ifdef SHIFT_PIPE_ROTATE_EN
            2'd3:    return (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
`endif
            default: return d >> sh;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            prst = reset;
        end
    end

    // Monitor / scoreboard, sampling on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (prst) begin
                check("rst_out_valid", out_valid, 1'b0);
                check("rst_out_data", out_data, 32'h0);
                check("rst_out_tag", out_tag, 4'h0);
            end
            if (reset) begin
                check("rst_in_ready", in_ready, 1'b1);
                q.delete();
                stall_prev = 1'b0;
                run = 0;
            end else begin
                check("in_ready", in_ready, !(out_valid && !out_ready));
                if (stall_prev) begin
                    check("hold_valid", out_valid, 1'b1);
                    check("hold_data", out_data, held_d);
                    check("hold_tag", out_tag, held_t);
                end
                run = out_valid ? run + 1 : 0;
                if (run > maxrun) maxrun = run;
                if (out_valid && !out_ready) stall_cnt++;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual data=%h tag=%h required none",
                                 out_data, out_tag);
                    end else begin
                        e = q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_tag", out_tag, e.tag);
                        if (e.chk) check("latency", cyc - e.cyc, LAT);
                    end
                end
                stall_prev = out_valid && !out_ready;
                held_d = out_data;
                held_t = out_tag;
                if (in_valid && in_ready) begin
                    e.data = use_exp ? exp_val : model(in_op, in_data, int'(in_shamt));
                    e.tag  = in_tag;
                    e.cyc  = cyc;
                    e.chk  = lat_chk;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                        input logic [3:0] tag);
        int n;
        bit acc;
        n = 0;
        in_valid = 1'b1;
        in_op = op;
        in_data = d;
        in_shamt = sh;
        in_tag = tag;
        do begin
            @(negedge clock);
            acc = in_ready && !reset;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual in_ready=0 required 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic sendx(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                         input logic [3:0] tag, input logic [31:0] ex);
        use_exp = 1'b1;
        exp_val = ex;
        send(op, d, sh, tag);
        use_exp = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    task automatic send_rand(input logic [3:0] tag);
        logic [31:0] d;
        case ($urandom_range(0, 4))
            0:       d = 32'h8000_0000;
            1:       d = 32'hFFFF_FFFF;
            2:       d = 32'h0000_0001;
            default: d = $urandom;
        endcase
        send(2'($urandom_range(0, 3)), d, 5'($urandom_range(0, 31)), tag);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Directed values with literal expectations and fixed latency.
        lat_chk = 1'b1;
        sendx(2'd2, 32'h8000_0000, 5'd16, 4'd1, 32'hFFFF_8000);
        wait_idle();
        sendx(2'd1, 32'h8000_0000, 5'd16, 4'd2, 32'h0000_8000);
        sendx(2'd0, 32'h0000_0001, 5'd31, 4'd3, 32'h8000_0000);
        sendx(2'd2, 32'h7FFF_FFFF, 5'd31, 4'd4, 32'h0000_0000);
        sendx(2'd2, 32'h8000_0000, 5'd31, 4'd5, 32'hFFFF_FFFF);
        sendx(2'd1, 32'h8000_0000, 5'd31, 4'd6, 32'h0000_0001);
        for (int i = 0; i < 4; i++)
            sendx(2'(i), 32'hA5C3_0F96, 5'd0, 4'(7 + i), 32'hA5C3_0F96);
`ifdef SHIFT_PIPE_ROTATE_EN
        sendx(2'd3, 32'h0000_0001, 5'd1, 4'd11, 32'h8000_0000);
        sendx(2'd3, 32'h1234_5678, 5'd8, 4'd12, 32'h7812_3456);
`else
        sendx(2'd3, 32'h0000_0001, 5'd1, 4'd11, 32'h0000_0000);
        sendx(2'd3, 32'h1234_5678, 5'd8, 4'd12, 32'h0012_3456);
`endif
        wait_idle();

        // Back-to-back stream of 8 with tags 0..7.
        maxrun = 0;
        for (int i = 0; i < 8; i++) send_rand(4'(i));
        wait_idle();
        check("stream_run", maxrun, 8);

        // Backpressure: drop out_ready for 4 cycles at the first result.
        lat_chk = 1'b0;
        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand(4'(i));
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 100) begin
                    @(posedge clock);
                    #1;
                    n++;
                end
                out_ready = 1'b0;
                repeat (4) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        wait_idle();
        check("stall_cycles", stall_cnt, 4);

        // Reset with 3 operands in flight, plus an input pulse during reset.
        for (int i = 0; i < 3; i++) send_rand(4'(i + 1));
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        in_tag = 4'hF;
        @(posedge clock);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (8) begin
            @(negedge clock);
            check("post_rst_valid", out_valid, 1'b0);
            check("post_rst_ready", in_ready, 1'b1);
        end
        @(posedge clock);
        #1;
        lat_chk = 1'b1;
        sendx(2'd0, 32'h0000_00F0, 5'd4, 4'd9, 32'h0000_0F00);
        wait_idle();

        // Randomised traffic with random backpressure and input gaps.
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clock);
                        #1;
                    end
                    send_rand(4'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clock);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
